// File: rtl/bcd_to_bin_seq_if.sv
// Start/ready handshake and result bus of the packed-BCD to binary converter.
interface bcd_to_bin_seq_if #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  ready;
  logic                  done;
  logic                  err;
  logic [BIN_W-1:0]      bin_out;

  modport master (output start, bcd_in, input ready, done, err, bin_out);
  modport slave  (input start, bcd_in, output ready, done, err, bin_out);
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter: one digit per clock, MSD first,
// acc <= acc*10 + digit, with a sticky flag for any nibble above 9.
module bcd_to_bin_seq #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic              clk,
  input  logic              rst,
  bcd_to_bin_seq_if.slave   bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned EXT_W = BIN_W + 4;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t           r_state,    w_state_nxt;
  logic [BCD_W-1:0] r_shadow,   w_shadow_nxt;
  logic [BIN_W-1:0] r_acc,      w_acc_nxt;
  logic [IDX_W-1:0] r_idx,      w_idx_nxt;
  logic             r_err_flag, w_err_flag_nxt;
  logic             r_ready,    w_ready_nxt;
  logic             r_done,     w_done_nxt;
  logic             r_err,      w_err_nxt;
  logic [BIN_W-1:0] r_bin,      w_bin_nxt;

  logic [3:0]       w_digit;
  logic             w_digit_bad;
  logic [EXT_W-1:0] w_acc_ext;
  logic [BIN_W-1:0] w_acc_new;

  // Shadow is shifted left each CONV cycle, so the current digit is always the top nibble.
  assign w_digit     = r_shadow[BCD_W-1 -: 4];
  assign w_digit_bad = (w_digit > 4'd9);
  assign w_acc_ext   = (EXT_W'(r_acc) << 3) + (EXT_W'(r_acc) << 1) + EXT_W'(w_digit);
  assign w_acc_new   = w_acc_ext[BIN_W-1:0];

  always_comb begin
    w_state_nxt    = r_state;
    w_shadow_nxt   = r_shadow;
    w_acc_nxt      = r_acc;
    w_idx_nxt      = r_idx;
    w_err_flag_nxt = r_err_flag;
    w_ready_nxt    = r_ready;
    w_done_nxt     = 1'b0;
    w_err_nxt      = r_err;
    w_bin_nxt      = r_bin;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_shadow_nxt   = bus.bcd_in;
          w_acc_nxt      = '0;
          w_err_flag_nxt = 1'b0;
          w_idx_nxt      = IDX_LAST;
          w_ready_nxt    = 1'b0;
          w_state_nxt    = S_CONV;
        end
      end
      S_CONV: begin
        w_acc_nxt      = w_acc_new;
        w_shadow_nxt   = r_shadow << 4;
        w_err_flag_nxt = r_err_flag | w_digit_bad;
        if (r_idx == '0) begin
          w_bin_nxt   = (r_err_flag | w_digit_bad) ? '0 : w_acc_new;
          w_err_nxt   = r_err_flag | w_digit_bad;
          w_done_nxt  = 1'b1;
          w_ready_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_idx_nxt = r_idx - IDX_W'(1);
        end
      end
      default: begin
        w_ready_nxt = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shadow   <= '0;
      r_acc      <= '0;
      r_idx      <= '0;
      r_err_flag <= 1'b0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_bin      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_shadow   <= w_shadow_nxt;
      r_acc      <= w_acc_nxt;
      r_idx      <= w_idx_nxt;
      r_err_flag <= w_err_flag_nxt;
      r_ready    <= w_ready_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_bin      <= w_bin_nxt;
    end
  end

  assign bus.ready   = r_ready;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.bin_out = r_bin;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: directed vector table, handshake
// corner cases and random words against a decimal arithmetic reference.
module tb_bcd_to_bin_seq;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned BIN_W  = 14;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  bcd_to_bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic [13:0] bin;
    logic        err;
    string       name;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Decimal meaning of a packed BCD word; a bad nibble forces a zero result.
  function automatic void model(input logic [15:0] b, output logic [13:0] bin, output logic e);
    int unsigned v;
    int unsigned d;
    logic [15:0] t;
    v = 0;
    e = 1'b0;
    t = b;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      d = int'((t >> (4 * k)) & 16'hF);
      if (d > 9) e = 1'b1;
      v = v * 10 + d;
    end
    bin = e ? 14'd0 : 14'(v % 16384);
  endfunction

  // Entered and left at posedge+1; leaves right after the done cycle unless chk_pulse.
  task automatic conv(input logic [15:0] bcd, input logic [13:0] eb, input logic ee,
                      input string nm, input bit chk_pulse);
    int n;
    check({nm, ".ready_before"}, 32'(bus.ready), 32'd1);
    bus.start  = 1'b1;
    bus.bcd_in = bcd;
    tick();
    bus.start  = 1'b0;
    bus.bcd_in = ~bcd;
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      check({nm, ".ready_busy"}, 32'(bus.ready), 32'd0);
      tick();
      n++;
    end
    check({nm, ".latency"}, 32'(n), 32'(DIGITS));
    check({nm, ".bin"}, 32'(bus.bin_out), 32'(eb));
    check({nm, ".err"}, 32'(bus.err), 32'(ee));
    check({nm, ".ready_done"}, 32'(bus.ready), 32'd1);
    if (chk_pulse) begin
      tick();
      check({nm, ".done_pulse"}, 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    logic [15:0] rb;
    logic [13:0] mb;
    logic        me;
    int          dones;

    tbl[0] = '{16'h1234, 14'h04D2, 1'b0, "v1234"};
    tbl[1] = '{16'h9999, 14'h270F, 1'b0, "v9999"};
    tbl[2] = '{16'h0000, 14'h0000, 1'b0, "v0000"};
    tbl[3] = '{16'h12A4, 14'h0000, 1'b1, "v12A4"};
    tbl[4] = '{16'h0042, 14'h002A, 1'b0, "v0042"};
    tbl[5] = '{16'h0999, 14'h03E7, 1'b0, "v0999"};
    tbl[6] = '{16'hF000, 14'h0000, 1'b1, "vF000"};
    tbl[7] = '{16'h1000, 14'h03E8, 1'b0, "v1000"};

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("rst.ready", 32'(bus.ready), 32'd1);
    check("rst.done",  32'(bus.done),  32'd0);
    check("rst.err",   32'(bus.err),   32'd0);
    check("rst.bin",   32'(bus.bin_out), 32'd0);

    for (int i = 0; i < 8; i++) begin
      conv(tbl[i].bcd, tbl[i].bin, tbl[i].err, tbl[i].name, 1'b1);
      tick();
    end

    // Outputs hold across idle cycles.
    repeat (3) tick();
    check("hold.bin", 32'(bus.bin_out), 32'h03E8);

    // Back-to-back: second start on the done cycle.
    conv(16'h9999, 14'h270F, 1'b0, "b2b_a", 1'b0);
    conv(16'h0000, 14'h0000, 1'b0, "b2b_b", 1'b1);

    // Starts while busy are dropped.
    bus.start  = 1'b1;
    bus.bcd_in = 16'h0007;
    tick();
    bus.bcd_in = 16'h0500;
    dones = 0;
    for (int c = 0; c < 3; c++) begin
      check("ign.ready_busy", 32'(bus.ready), 32'd0);
      tick();
    end
    bus.start = 1'b0;
    tick();
    check("ign.done", 32'(bus.done), 32'd1);
    check("ign.bin",  32'(bus.bin_out), 32'd7);
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    check("ign.extra_done", 32'(dones), 32'd0);

    // Reset during the second CONV cycle.
    bus.start  = 1'b1;
    bus.bcd_in = 16'h5678;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.ready", 32'(bus.ready), 32'd1);
    check("abort.bin",   32'(bus.bin_out), 32'd0);
    check("abort.done",  32'(bus.done), 32'd0);
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    check("abort.no_done", 32'(dones), 32'd0);
    conv(16'h0001, 14'd1, 1'b0, "post_abort", 1'b1);

    for (int i = 0; i < 40; i++) begin
      rb = '0;
      for (int k = 0; k < DIGITS; k++) begin
        rb = rb << 4;
        if ($urandom_range(0, 9) == 0) rb[3:0] = 4'($urandom_range(10, 15));
        else                           rb[3:0] = 4'($urandom_range(0, 9));
      end
      model(rb, mb, me);
      conv(rb, mb, me, $sformatf("rnd%0d_%h", i, rb), 1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
